arbitro_round_robin: RTL and testbench
======================================

# arbitro_round_robin

Round-robin arbiter that shares one resource among `N` requesters, granting exclusive ownership to one requester at a time. It sits in front of the shared resource, for example a single FSM/datapath instance or an output device. Each requester holds `req` high for as long as it needs the resource. The arbiter enforces a maximum hold time, so no requester can starve the others.

## Interface
- `N`, 4: number of requesters; must be 2 or more.
- `MAX_HOLD`, 8: maximum consecutive cycles one grant may last; must be 1 or more.

- `Clock` input, 1 bit: the only clock; all state updates on its rising edge.
- `Reset` input, 1 bit: synchronous, active-high; sampled on the rising edge of `Clock`.
- `req` input, `N` bits: request lines; bit i is requester i.
- `grant` output, `N` bits: registered, one-hot or zero; bit i means requester i owns the resource.
- `grant_id` output, `$clog2(N)` bits: index of the current grant, or of the last grant when idle.
- `busy` output, 1 bit: high exactly when `grant` is non-zero.
- `timeout` output, 1 bit: one-cycle pulse when a grant is revoked because `MAX_HOLD` was reached.

## Operation
- States:
  - OCIOSO: no grant, no release pending.
  - CONCEDIDO: a grant is active.
  - LIBERA: a one-cycle release gap.
- Internal registers:
  - Priority pointer `ptr`: `$clog2(N)` bits.
  - Hold counter `cnt`: `$clog2(MAX_HOLD+1)` bits.
- Arbitration function:
  - Scan `req` starting at index `ptr`, ascending, wrapping from N-1 to 0.
  - The first set bit wins.
  - This function is evaluated only in OCIOSO and LIBERA.
- OCIOSO:
  - If any `req` bit is set, go to CONCEDIDO. Set `grant` to the winner's one-hot, `grant_id` to the winner's index, and `cnt` to 1.
  - Otherwise stay in OCIOSO.
- CONCEDIDO, with g = `grant_id`:
  - If `req[g]` is 0, go to LIBERA, clear `grant`, set `ptr` to (g+1) mod N, and keep `timeout` at 0.
  - Otherwise, if `cnt` equals `MAX_HOLD`, go to LIBERA, clear `grant`, set `ptr` to (g+1) mod N, and pulse `timeout` for one cycle.
  - Otherwise increment `cnt` and stay.
- LIBERA:
  - If any `req` bit is set, arbitrate from the updated `ptr` and go to CONCEDIDO as in OCIOSO.
  - Otherwise go to OCIOSO.
- Requests from non-granted requesters are ignored while in CONCEDIDO.
- `grant_id` holds its value through LIBERA and OCIOSO.
- A timed-out requester that keeps `req` high is treated like any other requester. It regains the grant only once the requesters ahead of it in pointer order have no pending request.

## Timing
- Reset values:
  - `grant` = 0, `grant_id` = 0, `busy` = 0, `timeout` = 0.
  - State = OCIOSO, `ptr` = 0, `cnt` = 0.
  - Requester 0 therefore has the highest priority after reset.
- Reset asserted mid-grant clears `grant` at that same rising edge. Reset wins over every other event.
- Grant latency: `req` sampled high at edge k in OCIOSO gives `grant` high after edge k.
- Release:
  - `req[g]` sampled low at edge k gives `grant` 0 after edge k.
  - The earliest next grant appears after edge k+1.
  - There is always at least one zero-grant cycle between two owners, including handover to the same requester.
- Maximum hold: `grant` stays high for exactly `MAX_HOLD` cycles when `req[g]` remains high. `timeout` is high during the first LIBERA cycle.
- If `req[g]` drops at the same edge where `cnt` equals `MAX_HOLD`, the release is normal and `timeout` stays 0.
- `busy` and `grant` change on the same edges.
- `grant` is never multi-hot.

## Test plan
- **Reset and single request.** Assert `Reset` for 2 cycles, then `req`=0100 held for 3 cycles, then 0. Required: all outputs 0 during reset; `grant`=0100 and `grant_id`=2 one cycle after `req` rises; `grant` lasts 3 cycles; then one LIBERA cycle; `timeout`=0 throughout.
- **Round-robin rotation.** `req`=1111; each owner drops its bit after 2 cycles of grant, then re-raises it. Required: grant order 0,1,2,3,0, each separated by exactly one zero-grant cycle.
- **Timeout.** `MAX_HOLD`=8; `req`=0001 held constantly. Required: `grant`=0001 for exactly 8 cycles; `timeout`=1 for one cycle; requester 0 re-granted after one gap cycle.
- **Timeout with competitor.** `req`=0011 held constantly. Required: 0 is granted for 8 cycles with a `timeout` pulse, then 1 is granted for 8 cycles, alternating.
- **Simultaneous drop at limit.** `req[0]` is dropped exactly on the 8th grant cycle. Required: `timeout` stays 0.
- **Reset mid-grant.** Assert `Reset` on the 3rd grant cycle of requester 2 while `req`=0110. Required: `grant`=0 after that edge; after reset releases, requester 1 is granted because `ptr` is 0 again.

Source files
------------

// File: rtl/arbitro_round_robin.sv
// arbitro_round_robin
//   Round-robin arbiter sharing one resource among N requesters, with a
//   bounded hold time so that no requester can starve the others.
//
// Ports
//   Clock       : single clock, rising edge
//   Reset       : synchronous, active-high
//   req         : request lines, bit i = requester i
//   grant       : registered grant, one-hot or zero
//   grant_id    : index of the current grant (held through idle/release)
//   busy        : high exactly when grant is non-zero
//   timeout     : one-cycle pulse when a grant is revoked at MAX_HOLD
//   o_dbg_state : current FSM state (OCIOSO=0, CONCEDIDO=1, LIBERA=2)
//
// Handshake: a requester owns the resource from the cycle its grant bit
// is high until it drops req (or is revoked at MAX_HOLD); a release is
// always followed by at least one cycle with grant == 0.
module arbitro_round_robin #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N),
    localparam int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout,
    output logic [1:0]     o_dbg_state
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        CONCEDIDO = 2'd1,
        LIBERA    = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_grant;
    logic [IDW-1:0] r_grant_id;
    logic           r_busy;
    logic           r_timeout;
    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_cnt;

    logic           w_found;
    logic [IDW-1:0] w_idx;
    logic [N-1:0]   w_onehot;
    logic [IDW-1:0] w_next_ptr;

    // Scan req from r_ptr upward, wrapping at N-1; first set bit wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(r_ptr) + k;
            if (j >= N) j = j - N;
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_idx   = IDW'(j);
            end
        end
        w_onehot = {{(N-1){1'b0}}, 1'b1} << w_idx;
    end

    // Priority moves to the requester just after the one released.
    assign w_next_ptr = (r_grant_id == IDW'(N - 1)) ? '0 : r_grant_id + IDW'(1);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= OCIOSO;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                OCIOSO, LIBERA: begin
                    if (w_found) begin
                        r_state    <= CONCEDIDO;
                        r_grant    <= w_onehot;
                        r_grant_id <= w_idx;
                        r_busy     <= 1'b1;
                        r_cnt      <= CW'(1);
                    end else begin
                        r_state <= OCIOSO;
                    end
                end
                CONCEDIDO: begin
                    // A voluntary drop takes precedence over the hold limit,
                    // so a drop on the last allowed cycle is not a timeout.
                    if (!req[r_grant_id]) begin
                        r_state <= LIBERA;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_next_ptr;
                    end else if (r_cnt == CW'(MAX_HOLD)) begin
                        r_state   <= LIBERA;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_ptr     <= w_next_ptr;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= OCIOSO;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign busy        = r_busy;
    assign timeout     = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_arbitro_round_robin.sv
module tb_arbitro_round_robin;

    localparam int N   = 4;
    localparam int MH  = 8;
    localparam int IDW = 2;
    localparam int W   = N + IDW + 2;

    logic           Clock;
    logic           Reset;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout;
    logic [1:0]     o_dbg_state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks;
    int           n_fail;

    arbitro_round_robin #(.N(N), .MAX_HOLD(MH)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout     (timeout),
        .o_dbg_state (o_dbg_state)
    );

    // Clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Driver: apply inputs for the next rising edge and queue the outputs
    // expected right after that edge.
    task automatic step(input string nm, input logic rst, input logic [N-1:0] rq,
                        input logic [N-1:0] g, input int id, input logic t);
        @(negedge Clock);
        Reset = rst;
        req   = rq;
        exp_q.push_back({g, IDW'(id), (g != '0), t});
        name_q.push_back(nm);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] act;
        string        nm;
        forever begin
            @(posedge Clock);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {grant, grant_id, busy, timeout};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got grant=%b id=%0d busy=%b timeout=%b, expected grant=%b id=%0d busy=%b timeout=%b",
                             nm, $time, act[W-1 -: N], act[2 +: IDW], act[1], act[0],
                             e[W-1 -: N], e[2 +: IDW], e[1], e[0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        req      = '0;

        // Reset and single request
        repeat (2) step("reset", 1, 4'b0000, 4'b0000, 0, 0);
        repeat (3) step("single_grant", 0, 4'b0100, 4'b0100, 2, 0);
        step("single_release", 0, 4'b0000, 4'b0000, 2, 0);
        step("single_idle", 0, 4'b0000, 4'b0000, 2, 0);

        // Round-robin rotation 0,1,2,3,0
        step("rr_reset", 1, 4'b0000, 4'b0000, 0, 0);
        for (int i = 0; i < N; i++) begin
            logic [N-1:0] oh;
            oh = 4'b0001 << i;
            repeat (2) step("rr_grant", 0, 4'b1111, oh, i, 0);
            step("rr_gap", 0, 4'b1111 & ~oh, 4'b0000, i, 0);
        end
        step("rr_wrap", 0, 4'b1111, 4'b0001, 0, 0);
        step("rr_release", 0, 4'b0000, 4'b0000, 0, 0);
        step("rr_idle", 0, 4'b0000, 4'b0000, 0, 0);

        // Timeout with a single requester
        repeat (MH) step("to_hold", 0, 4'b0001, 4'b0001, 0, 0);
        step("to_pulse", 0, 4'b0001, 4'b0000, 0, 1);
        step("to_regrant", 0, 4'b0001, 4'b0001, 0, 0);
        step("to_release", 0, 4'b0000, 4'b0000, 0, 0);
        step("to_idle", 0, 4'b0000, 4'b0000, 0, 0);

        // Timeout with competitor: 0 and 1 alternate
        step("comp_reset", 1, 4'b0000, 4'b0000, 0, 0);
        repeat (MH) step("comp_hold0", 0, 4'b0011, 4'b0001, 0, 0);
        step("comp_pulse0", 0, 4'b0011, 4'b0000, 0, 1);
        repeat (MH) step("comp_hold1", 0, 4'b0011, 4'b0010, 1, 0);
        step("comp_pulse1", 0, 4'b0011, 4'b0000, 1, 1);
        step("comp_back0", 0, 4'b0011, 4'b0001, 0, 0);
        step("comp_release", 0, 4'b0000, 4'b0000, 0, 0);
        step("comp_idle", 0, 4'b0000, 4'b0000, 0, 0);

        // Drop exactly at the hold limit: normal release, no timeout
        repeat (MH) step("lim_hold", 0, 4'b0001, 4'b0001, 0, 0);
        step("lim_drop", 0, 4'b0000, 4'b0000, 0, 0);
        step("lim_idle", 0, 4'b0000, 4'b0000, 0, 0);

        // Reset mid-grant: move ptr to 2, grant 2, reset on its 3rd cycle
        step("mid_prep_grant1", 0, 4'b0010, 4'b0010, 1, 0);
        step("mid_prep_release", 0, 4'b0000, 4'b0000, 1, 0);
        step("mid_prep_idle", 0, 4'b0000, 4'b0000, 1, 0);
        repeat (2) step("mid_grant2", 0, 4'b0110, 4'b0100, 2, 0);
        step("mid_reset", 1, 4'b0110, 4'b0000, 0, 0);
        step("mid_after_reset", 0, 4'b0110, 4'b0010, 1, 0);
        step("mid_release", 0, 4'b0000, 4'b0000, 1, 0);
        step("mid_idle", 0, 4'b0000, 4'b0000, 1, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge Clock);
        @(negedge Clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
